div_issue_queue: RTL and testbench

Request buffer placed directly upstream of the scalar integer divider. It accepts division/remainder requests from the issue stage at up to one per cycle and holds them in order in a small FIFO. It hands requests to the divider one at a time, only while the divider reports `ready`, so a busy divider never stalls the issue stage until the queue is full. It also drops every pending request on a pipeline flush.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_issue_queue_if.sv | 44 ++++
 rtl/div_req_fifo.sv | 81 ++++++++
 rtl/div_issue_queue.sv | 68 ++++++
 tb/tb_div_issue_queue.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and widths for the divider request path.
package div_pkg;

  localparam int unsigned DIV_DATA_W   = 32;
  localparam int unsigned DIV_DEST_W   = 6;
  localparam int unsigned DIV_TICKET_W = 3;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef struct packed {
    div_op_e                 op_type;
    logic [DIV_DEST_W-1:0]   destination;
    logic [DIV_TICKET_W-1:0] ticket;
    logic [DIV_DATA_W-1:0]   dividend;
    logic [DIV_DATA_W-1:0]   divider;
  } div_req_t;

endpackage

// File: rtl/div_issue_queue_if.sv
// Issue-stage and divider-side signals of the divider request queue.
interface div_issue_queue_if
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_op_type;
  logic [DIV_DEST_W-1:0]   in_destination;
  logic [DIV_TICKET_W-1:0] in_ticket;
  logic [DATA_WIDTH-1:0]   in_dividend;
  logic [DATA_WIDTH-1:0]   in_divider;
  logic                    div_ready;
  logic                    div_enable;
  logic [1:0]              div_op_type;
  logic [DIV_DEST_W-1:0]   div_destination;
  logic [DIV_TICKET_W-1:0] div_ticket;
  logic [DATA_WIDTH-1:0]   div_dividend;
  logic [DATA_WIDTH-1:0]   div_divider;
  logic [CNT_W-1:0]        count;

  // Driver side: issue stage plus the divider's ready.
  modport master (
    output flush, in_valid, in_op_type, in_destination, in_ticket,
           in_dividend, in_divider, div_ready,
    input  in_ready, div_enable, div_op_type, div_destination, div_ticket,
           div_dividend, div_divider, count
  );

  // Queue side.
  modport slave (
    input  flush, in_valid, in_op_type, in_destination, in_ticket,
           in_dividend, in_divider, div_ready,
    output in_ready, div_enable, div_op_type, div_destination, div_ticket,
           div_dividend, div_divider, count
  );

endinterface

// File: rtl/div_req_fifo.sv
// In-order FIFO of divider requests; occupancy count decides full/empty.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  div_req_t         push_data,
  input  logic             pop,
  output div_req_t         head_data_c,
  output logic [CNT_W-1:0] count,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  div_req_t         mem_q [DEPTH];
  div_req_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_c      = (count_q == CNT_W'(DEPTH));
  assign empty_c     = (count_q == '0);
  assign head_data_c = mem_q[rd_ptr_q];
  assign count       = count_q;

  // Next-state: flush wins over push/pop; pointers wrap at the power-of-two depth.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full_c && !flush;
    do_pop   = pop && !empty_c && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy guards its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/div_issue_queue.sv
// Request buffer in front of the integer divider: issues only while the divider is idle.
module div_issue_queue
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input logic              clk,
  input logic              rst,
  div_issue_queue_if.slave q
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  div_req_t         push_req;
  div_req_t         head_req;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue;

  // Pack the incoming request.
  always_comb begin
    push_req             = '0;
    push_req.op_type     = div_op_e'(q.in_op_type);
    push_req.destination = q.in_destination;
    push_req.ticket      = q.in_ticket;
    push_req.dividend    = DIV_DATA_W'(q.in_dividend);
    push_req.divider     = DIV_DATA_W'(q.in_divider);
  end

  div_req_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (q.flush),
    .push        (q.in_valid),
    .push_data   (push_req),
    .pop         (issue),
    .head_data_c (head_req),
    .count       (fifo_count),
    .full_c      (fifo_full),
    .empty_c     (fifo_empty)
  );

  // Issue gating against divider ready, and payload zeroing when not issuing.
  always_comb begin
    issue             = !fifo_empty && q.div_ready && !q.flush && !rst;
    q.in_ready        = rst || !fifo_full;
    q.count           = fifo_count;
    q.div_enable      = issue;
    q.div_op_type     = '0;
    q.div_destination = '0;
    q.div_ticket      = '0;
    q.div_dividend    = '0;
    q.div_divider     = '0;
    if (issue) begin
      q.div_op_type     = head_req.op_type;
      q.div_destination = head_req.destination;
      q.div_ticket      = head_req.ticket;
      q.div_dividend    = DATA_WIDTH'(head_req.dividend);
      q.div_divider     = DATA_WIDTH'(head_req.divider);
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue.
module tb_div_issue_queue;

  logic clk = 1'b0;
  logic rst;
  int   n_total  = 0;
  int   n_passed = 0;

  always #5 clk = ~clk;

  div_issue_queue_if #(.DATA_WIDTH(32), .DEPTH(4)) q_if ();

  div_issue_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [1:0] op, input logic [5:0] dst,
                         input logic [2:0] tk, input logic [31:0] a, input logic [31:0] b);
    q_if.in_valid       = v;
    q_if.in_op_type     = op;
    q_if.in_destination = dst;
    q_if.in_ticket      = tk;
    q_if.in_dividend    = a;
    q_if.in_divider     = b;
  endtask

  initial begin
    int push_idx;
    int pop_idx;
    int budget;
    logic acc;

    rst = 1'b1;
    q_if.flush = 1'b0;
    q_if.div_ready = 1'b1;
    set_req(1'b0, 2'd0, 6'd0, 3'd0, 32'd0, 32'd0);

    // Reset behaviour
    #1;
    chk("rst_in_ready", 64'(q_if.in_ready), 64'd1);
    chk("rst_enable", 64'(q_if.div_enable), 64'd0);
    chk("rst_payload", 64'(q_if.div_dividend), 64'd0);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_count", 64'(q_if.count), 64'd0);
    chk("post_rst_enable", 64'(q_if.div_enable), 64'd0);

    // Single DIV, issue next cycle
    set_req(1'b1, 2'd0, 6'd5, 3'd1, 32'd100, 32'd7);
    #1;
    chk("t1_no_bypass", 64'(q_if.div_enable), 64'd0);
    cyc();
    set_req(1'b0, 2'd0, 6'd0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("t1_count1", 64'(q_if.count), 64'd1);
    chk("t1_enable", 64'(q_if.div_enable), 64'd1);
    chk("t1_op", 64'(q_if.div_op_type), 64'd0);
    chk("t1_dest", 64'(q_if.div_destination), 64'd5);
    chk("t1_ticket", 64'(q_if.div_ticket), 64'd1);
    chk("t1_dividend", 64'(q_if.div_dividend), 64'd100);
    chk("t1_divider", 64'(q_if.div_divider), 64'd7);
    cyc();
    chk("t1_count0", 64'(q_if.count), 64'd0);
    chk("t1_idle", 64'(q_if.div_enable), 64'd0);

    // Fill with divider busy
    q_if.div_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'd1, 6'(10 + i), 3'(i), 32'(i * 3 + 1), 32'd9);
      #1;
      chk("t2_in_ready", 64'(q_if.in_ready), 64'd1);
      chk("t2_no_issue_busy", 64'(q_if.div_enable), 64'd0);
      cyc();
    end
    set_req(1'b0, 2'd0, 6'd0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("t2_full_count", 64'(q_if.count), 64'd4);
    chk("t2_full_ready", 64'(q_if.in_ready), 64'd0);
    set_req(1'b1, 2'd1, 6'd20, 3'd6, 32'd77, 32'd1);
    cyc();
    chk("t2_fifth_rejected", 64'(q_if.count), 64'd4);

    // Full queue: issue and push in the same cycle, push rejected
    set_req(1'b1, 2'd1, 6'd21, 3'd7, 32'd88, 32'd1);
    q_if.div_ready = 1'b1;
    #1;
    chk("t3_in_ready_full", 64'(q_if.in_ready), 64'd0);
    chk("t3_enable", 64'(q_if.div_enable), 64'd1);
    chk("t3_ticket0", 64'(q_if.div_ticket), 64'd0);
    chk("t3_dividend0", 64'(q_if.div_dividend), 64'd1);
    cyc();
    set_req(1'b0, 2'd0, 6'd0, 3'd0, 32'd0, 32'd0);
    q_if.div_ready = 1'b0;
    #1;
    chk("t3_count3", 64'(q_if.count), 64'd3);
    chk("t3_in_ready_free", 64'(q_if.in_ready), 64'd1);
    chk("t3_busy_no_issue", 64'(q_if.div_enable), 64'd0);
    cyc();
    for (int i = 1; i < 4; i++) begin
      q_if.div_ready = 1'b1;
      #1;
      chk("t2_order_en", 64'(q_if.div_enable), 64'd1);
      chk("t2_order_ticket", 64'(q_if.div_ticket), 64'(i));
      chk("t2_order_dest", 64'(q_if.div_destination), 64'(10 + i));
      cyc();
      q_if.div_ready = 1'b0;
      #1;
      chk("t2_gap_en", 64'(q_if.div_enable), 64'd0);
      cyc();
    end
    chk("t2_drained", 64'(q_if.count), 64'd0);

    // Flush with 3 queued, simultaneous push and ready
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 2'd2, 6'(30 + i), 3'(4 + i), 32'(500 + i), 32'd3);
      cyc();
    end
    chk("t4_count3", 64'(q_if.count), 64'd3);
    set_req(1'b1, 2'd3, 6'd40, 3'd7, 32'd999, 32'd2);
    q_if.flush = 1'b1;
    q_if.div_ready = 1'b1;
    #1;
    chk("t4_flush_no_issue", 64'(q_if.div_enable), 64'd0);
    chk("t4_flush_payload0", 64'(q_if.div_ticket), 64'd0);
    cyc();
    q_if.flush = 1'b0;
    set_req(1'b0, 2'd0, 6'd0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("t4_count0", 64'(q_if.count), 64'd0);
    chk("t4_dropped_push", 64'(q_if.div_enable), 64'd0);
    cyc();
    chk("t4_still_empty", 64'(q_if.count), 64'd0);

    // Wrap-around stream with random divider readiness
    push_idx = 0;
    pop_idx  = 0;
    budget   = 0;
    while ((pop_idx < 10) && (budget < 300)) begin
      q_if.div_ready = 1'($urandom_range(0, 1));
      if (push_idx < 10)
        set_req(1'b1, 2'(push_idx % 4), 6'(push_idx), 3'(push_idx % 8),
                32'(push_idx * 37 + 1), 32'(push_idx + 2));
      else
        set_req(1'b0, 2'd0, 6'd0, 3'd0, 32'd0, 32'd0);
      #1;
      acc = q_if.in_valid && q_if.in_ready;
      if (q_if.div_enable) begin
        chk("t5_ready_gate", 64'(q_if.div_ready), 64'd1);
        chk("t5_ticket", 64'(q_if.div_ticket), 64'(pop_idx % 8));
        chk("t5_dividend", 64'(q_if.div_dividend), 64'(pop_idx * 37 + 1));
        pop_idx++;
      end
      cyc();
      if (acc) push_idx++;
      budget++;
    end
    chk("t5_all_issued", 64'(pop_idx), 64'd10);
    set_req(1'b0, 2'd0, 6'd0, 3'd0, 32'd0, 32'd0);
    q_if.div_ready = 1'b0;
    #1;
    chk("t5_empty", 64'(q_if.count), 64'd0);

    // Reset mid-stream with 2 queued
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, 2'd0, 6'(50 + i), 3'(i), 32'(700 + i), 32'd5);
      cyc();
    end
    set_req(1'b0, 2'd0, 6'd0, 3'd0, 32'd0, 32'd0);
    chk("t6_count2", 64'(q_if.count), 64'd2);
    rst = 1'b1;
    q_if.div_ready = 1'b1;
    #1;
    chk("t6_rst_no_issue", 64'(q_if.div_enable), 64'd0);
    chk("t6_rst_in_ready", 64'(q_if.in_ready), 64'd1);
    chk("t6_rst_payload", 64'(q_if.div_dividend), 64'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_count0", 64'(q_if.count), 64'd0);
    chk("t6_enable0", 64'(q_if.div_enable), 64'd0);
    chk("t6_payload0", 64'(q_if.div_destination), 64'd0);
    set_req(1'b1, 2'd3, 6'd63, 3'd7, 32'hFFFF_FFFF, 32'd3);
    #1;
    chk("t6_no_bypass", 64'(q_if.div_enable), 64'd0);
    cyc();
    set_req(1'b0, 2'd0, 6'd0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("t6_enable", 64'(q_if.div_enable), 64'd1);
    chk("t6_op", 64'(q_if.div_op_type), 64'd3);
    chk("t6_dest", 64'(q_if.div_destination), 64'd63);
    chk("t6_ticket", 64'(q_if.div_ticket), 64'd7);
    chk("t6_dividend", 64'(q_if.div_dividend), 64'hFFFF_FFFF);
    chk("t6_divider", 64'(q_if.div_divider), 64'd3);
    cyc();
    chk("t6_count_end", 64'(q_if.count), 64'd0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
